demux_frame_sequencer: RTL

Upstream driver for the 1-to-4 demultiplexer. Accepts a parallel payload word and a 2-bit destination through a valid/ready handshake. Serialises the payload MSB-first onto the demux data line `a`, holding `sel` at the destination for the whole frame. Keeps a wrapping per-channel frame counter for debug and verification.

---
 rtl/demux_frame_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/demux_frame_sequencer.sv
// demux_frame_sequencer: accepts a payload word and destination over valid/ready,
// serialises the payload MSB-first onto the demux data line while holding the
// demux select steady, and keeps a wrapping frame counter per channel.
// Optional feature macro: DEMUX_SEQ_PARITY_EN appends an even-parity bit to each frame.
module demux_frame_sequencer #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_dest,
  input  logic [DATA_W-1:0] in_data,
  output logic              a,
  output logic [1:0]        sel,
  output logic              frame,
  output logic              done,
  output logic [7:0]        cnt0,
  output logic [7:0]        cnt1,
  output logic [7:0]        cnt2,
  output logic [7:0]        cnt3
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_PREV = BW'(DATA_W - 2);
  localparam logic [3:0]    GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

`ifdef DEMUX_SEQ_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
`endif

  localparam state_e AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [3:0]        gap_q, gap_d;
  logic [1:0]        sel_q, sel_d;
  logic              a_q, a_d;
  logic              frame_q, frame_d;
  logic              done_q, done_d;
  logic [7:0]        cnt_q [4];
  logic [7:0]        cnt_d [4];
  logic              accept;
`ifdef DEMUX_SEQ_PARITY_EN
  logic              par_q, par_d;
`endif

  assign in_ready = (state_q == IDLE) && rst_n;
  assign accept   = in_valid && in_ready;

  assign a     = a_q;
  assign sel   = sel_q;
  assign frame = frame_q;
  assign done  = done_q;
  assign cnt0  = cnt_q[0];
  assign cnt1  = cnt_q[1];
  assign cnt2  = cnt_q[2];
  assign cnt3  = cnt_q[3];

  // Next-state and registered-output logic; a/frame/done are computed one cycle
  // ahead so the registered versions line up with the bit currently on the line.
  // The shift register holds the payload already shifted by one because the MSB
  // goes straight to a_q on the accept edge.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sel_d   = sel_q;
    a_d     = 1'b0;
    frame_d = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef DEMUX_SEQ_PARITY_EN
    par_d   = par_q;
`endif
    if (done_q) begin
      cnt_d[sel_q] = cnt_q[sel_q] + 8'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shift_d = {in_data[DATA_W-2:0], 1'b0};
          bit_d   = '0;
          sel_d   = in_dest;
          a_d     = in_data[DATA_W-1];
          frame_d = 1'b1;
`ifdef DEMUX_SEQ_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      SHIFT: begin
        if (bit_q == BIT_LAST) begin
`ifdef DEMUX_SEQ_PARITY_EN
          state_d = PAR;
          a_d     = par_q;
          frame_d = 1'b1;
          done_d  = 1'b1;
`else
          state_d = AFTER_FRAME;
          gap_d   = '0;
`endif
        end else begin
          a_d     = shift_q[DATA_W-1];
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          bit_d   = bit_q + BW'(1);
          frame_d = 1'b1;
`ifndef DEMUX_SEQ_PARITY_EN
          done_d  = (bit_q == BIT_PREV);
`endif
        end
      end
`ifdef DEMUX_SEQ_PARITY_EN
      PAR: begin
        state_d = AFTER_FRAME;
        gap_d   = '0;
      end
`endif
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset; a reset
  // mid-frame clears done_q before it can bump a counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sel_q   <= 2'b00;
      a_q     <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
`ifdef DEMUX_SEQ_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
`ifdef DEMUX_SEQ_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
